// File: rtl/fifo_reader.sv
// fifo_reader: pops an upstream fifo_buffer and re-presents its words, in
// order, on a valid/ready stream. A 2-entry skid buffer (head, tail) absorbs
// the one-cycle read latency of the FIFO, so a held out_ready=1 sustains one
// word per cycle. out_count tracks delivered words and wraps naturally.
module fifo_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count
);

    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;

    logic                  pop_out;
    logic [1:0]            occ_after;
    logic [1:0]            occ_next;
    logic [2:0]            pending;

    assign pop_out  = out_valid & out_ready;
    assign out_data = head;

    // Occupancy bookkeeping and pop decision: a new pop is only issued when the
    // word it fetches is guaranteed a free slot once it lands.
    always_comb begin
        occ_after  = occ - {1'b0, pop_out};
        occ_next   = occ_after + {1'b0, inflight};
        pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop_out};
        fifo_rd_en = reset & en & ~fifo_empty & (pending < 3'd2);
    end

    // Skid buffer: shift tail into head on delivery, land the in-flight word in
    // the first free slot, and count deliveries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ       <= 2'd0;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            inflight  <= fifo_rd_en;
            occ       <= occ_next;
            out_valid <= (occ_next != 2'd0);
            if (pop_out) begin
                head      <= tail;
                out_count <= out_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (inflight) begin
                if (occ_after == 2'd0) begin
                    head <= fifo_rd_data;
                end else begin
                    tail <= fifo_rd_data;
                end
            end
        end
    end

    // A word landing into a full buffer with nothing leaving would be lost.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        !(inflight && (occ == 2'd2) && !pop_out));

    // Occupancy is bounded by the two storage entries.
    a_occ_bound : assert property (@(posedge clk) disable iff (!reset)
        occ <= 2'd2);

    // Never pop an empty FIFO.
    a_no_empty_pop : assert property (@(posedge clk) disable iff (!reset)
        !(fifo_rd_en && fifo_empty));

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of the FIFO words and of the output stream.
REQ-002 Parameter CNT_WIDTH, default 8: width of the delivered-word counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 clears all state immediately, independent of clk.
REQ-005 en  input  1  1 permits new FIFO pops; 0 stops new pops while already-fetched words still drain.
REQ-006 fifo_empty  input  1  empty flag from fifo_buffer.
REQ-007 fifo_rd_data  input  DATA_WIDTH  read data from fifo_buffer; valid exactly one cycle after a pop.
REQ-008 fifo_rd_en  output  1  pop strobe to fifo_buffer.
REQ-009 out_valid  output  1  out_data holds a word.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 out_data  output  DATA_WIDTH  head word of the output stream.
REQ-012 out_count  output  CNT_WIDTH  number of words delivered since reset.

Function
REQ-013 The block shall pop fifo_buffer and present the words in FIFO order on a valid/ready stream with no loss or duplication.
REQ-014 Storage shall be a 2-entry skid buffer (head, tail) with occupancy occ in 0..2.
REQ-015 A pop shall be in flight (flag inflight) for exactly the cycle after fifo_rd_en=1.
REQ-016 fifo_rd_en shall be combinational: en & ~fifo_empty & (occ + inflight - pop_out < 2), where pop_out = out_valid & out_ready.
REQ-017 fifo_rd_en shall never be 1 while fifo_empty=1.
REQ-018 At the edge ending an in-flight cycle, fifo_rd_data shall be captured into the head if occ after this cycle's pop_out is 0, else into the tail.
REQ-019 On pop_out, tail shall move to head and occ shall drop by 1; a simultaneous capture and pop_out shall leave occ unchanged.
REQ-020 out_valid shall equal (occ != 0); out_data shall equal the head entry; both registered, no combinational path from fifo_rd_data.
REQ-021 Throughput: with fifo non-empty, en=1 and out_ready=1 held, one word shall be delivered per cycle after a 2-cycle start-up latency (pop at cycle N, out_valid at N+2 after the capture edge).
REQ-022 out_data and out_valid shall hold stable while out_valid=1 and out_ready=0.
REQ-023 out_count shall increment by 1 on each pop_out and wrap from all-ones to 0.
REQ-024 en=0 shall suppress new pops only; an in-flight word shall still be captured and buffered words still delivered.
REQ-025 occ shall never exceed 2; inflight=1 with occ=2 and no pop_out is unreachable and shall be checked by assertion.

Reset
REQ-026 While reset=0: fifo_rd_en=0, out_valid=0, out_data=0, out_count=0, occ=0, inflight=0, head=tail=0.
REQ-027 Reset asserted with a pop in flight shall discard that word; no capture after release.
REQ-028 After reset rises, the first pop shall occur no earlier than the first rising edge with reset=1.

Verification
REQ-029 Reset held 20 ns, then fifo loaded with 4'b0110 and 4'b1001, en=1, out_ready=1 -> fifo_rd_en pulses two consecutive cycles; out_data 4'b0110 then 4'b1001 on consecutive cycles; out_count=2.
REQ-030 Eight words 0..7 in fifo, out_ready=0 -> exactly two pops, out_valid=1, out_data=0 held stable; then out_ready=1 -> words 1..7 follow one per cycle, out_count=8.
REQ-031 fifo_empty=1 throughout, en=1 -> fifo_rd_en never asserted, out_valid stays 0.
REQ-032 en dropped the cycle after a pop of 4'b0011 -> that word still appears on out_data, no further pops while en=0.
REQ-033 reset pulsed low mid-stream with a pop in flight -> all outputs 0 immediately; after release, stream restarts from the next fifo word with out_count=0.
REQ-034 out_count preset by 255 deliveries, one more word -> out_count=0.
